skeleton_keypoint_finder: RTL

SKELETON_KEYPOINT_FINDER -- requirements
Module: skeleton_keypoint_finder

---
 rtl/skeleton_keypoint_finder_pkg.sv | 34 +++
 rtl/keypoint_fifo.sv | 45 ++++
 rtl/skeleton_keypoint_finder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/skeleton_keypoint_finder_pkg.sv
// Shared types for the skeleton keypoint finder: keypoint record, type encoding, FSM states.
package skeleton_keypoint_finder_pkg;

    localparam int unsigned KP_COORD_W = 12;
    localparam int unsigned COUNT_W    = 8;

    typedef enum logic {
        KP_ENDPOINT = 1'b0,
        KP_JUNCTION = 1'b1
    } kp_type_e;

    typedef struct packed {
        logic [KP_COORD_W-1:0] hcount;
        logic [KP_COORD_W-1:0] vcount;
        kp_type_e              kp_type;
    } keypoint_t;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        FINISH     = 2'd2
    } fsm_state_e;

    // Number of set bits among the eight window neighbours.
    function automatic logic [3:0] popcount8(input logic [7:0] bits);
        logic [3:0] sum;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + 4'(bits[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/keypoint_fifo.sv
// First-word-fall-through FIFO; a push while full succeeds only if a pop happens in the same cycle.
module keypoint_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is left unreset so it can map onto a plain RAM.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/skeleton_keypoint_finder.sv
// Finds skeleton endpoints and junctions in a raster pixel stream via a 3x3 window and queues them.
module skeleton_keypoint_finder
    import skeleton_keypoint_finder_pkg::*;
#(
    parameter int unsigned HORIZONTAL_COUNT = 320,
    parameter int unsigned VERTICAL_COUNT   = 180,
    parameter int unsigned FIFO_DEPTH       = 64
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [$clog2(HORIZONTAL_COUNT)-1:0] hcount_in,
    input  logic [$clog2(VERTICAL_COUNT)-1:0]   vcount_in,
    input  logic                                skeleton_in,
    input  logic                                pixel_valid_in,
    output logic                                keypoint_valid_out,
    input  logic                                keypoint_ready_in,
    output logic [$clog2(HORIZONTAL_COUNT)-1:0] keypoint_hcount_out,
    output logic [$clog2(VERTICAL_COUNT)-1:0]   keypoint_vcount_out,
    output logic                                keypoint_type_out,
    output logic [7:0]                          endpoint_count_out,
    output logic [7:0]                          junction_count_out,
    output logic                                overflow_out,
    output logic                                frame_done_out
);

    localparam int unsigned HWIDTH = $clog2(HORIZONTAL_COUNT);
    localparam int unsigned VWIDTH = $clog2(VERTICAL_COUNT);
    localparam int unsigned KP_W   = $bits(keypoint_t);

    fsm_state_e                  state_q;
    fsm_state_e                  state_d;
    logic                        frame_start_c;
    logic                        frame_end_c;

    logic [HORIZONTAL_COUNT-1:0] row1_q;
    logic [HORIZONTAL_COUNT-1:0] row2_q;
    logic [2:0]                  col_prev_q;
    logic [2:0]                  col_centre_q;
    logic [2:0]                  col_new_c;
    logic [7:0]                  neigh_c;
    logic [3:0]                  ncount_c;
    logic                        centre_ok_c;
    logic                        is_end_c;
    logic                        is_junc_c;

    keypoint_t                   kp_q;
    logic                        kp_valid_q;
    logic [COUNT_W-1:0]          ep_run_q;
    logic [COUNT_W-1:0]          jn_run_q;

    logic [KP_W-1:0]             head_bits;
    keypoint_t                   head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_pop;
    logic                        fifo_drop;

    assign frame_start_c = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
    assign frame_end_c   = pixel_valid_in && (state_q == ACTIVE)
                         && (hcount_in == HWIDTH'(HORIZONTAL_COUNT - 1))
                         && (vcount_in == VWIDTH'(VERTICAL_COUNT - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= WAIT_FRAME;
        else        state_q <= state_d;
    end

    // A pixel at (0,0) always (re)starts a frame, whatever the current state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FRAME: if (frame_start_c) state_d = ACTIVE;
            ACTIVE:     if (!frame_start_c && frame_end_c) state_d = FINISH;
            FINISH:     state_d = frame_start_c ? ACTIVE : WAIT_FRAME;
            default:    state_d = WAIT_FRAME;
        endcase
    end

    // Window columns: bit 2 = row v-2, bit 1 = row v-1, bit 0 = row v.
    assign col_new_c = {row2_q[hcount_in], row1_q[hcount_in], skeleton_in};

    always_ff @(posedge clk_in) begin
        if (pixel_valid_in) begin
            row2_q[hcount_in] <= row1_q[hcount_in];
            row1_q[hcount_in] <= skeleton_in;
            col_prev_q        <= col_centre_q;
            col_centre_q      <= col_new_c;
        end
    end

    assign neigh_c     = {col_prev_q, col_centre_q[2], col_centre_q[0], col_new_c};
    assign ncount_c    = popcount8(neigh_c);
    assign centre_ok_c = pixel_valid_in && (state_q == ACTIVE) && !frame_start_c
                       && (hcount_in >= HWIDTH'(2)) && (vcount_in >= VWIDTH'(2))
                       && col_centre_q[1];
    assign is_end_c    = centre_ok_c && (ncount_c == 4'd1);
    assign is_junc_c   = centre_ok_c && (ncount_c >= 4'd3);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            kp_valid_q <= 1'b0;
            kp_q       <= '0;
        end else begin
            kp_valid_q <= is_end_c || is_junc_c;
            if (is_end_c || is_junc_c) begin
                kp_q.hcount  <= KP_COORD_W'(hcount_in - HWIDTH'(1));
                kp_q.vcount  <= KP_COORD_W'(vcount_in - VWIDTH'(1));
                kp_q.kp_type <= is_junc_c ? KP_JUNCTION : KP_ENDPOINT;
            end
        end
    end

    // Running counts include keypoints later dropped by a full queue.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ep_run_q           <= '0;
            jn_run_q           <= '0;
            endpoint_count_out <= '0;
            junction_count_out <= '0;
            overflow_out       <= 1'b0;
        end else begin
            if (frame_start_c) begin
                ep_run_q <= '0;
                jn_run_q <= '0;
            end else begin
                if (is_end_c && (ep_run_q != '1))  ep_run_q <= ep_run_q + COUNT_W'(1);
                if (is_junc_c && (jn_run_q != '1)) jn_run_q <= jn_run_q + COUNT_W'(1);
            end
            if (state_q == FINISH) begin
                endpoint_count_out <= ep_run_q;
                junction_count_out <= jn_run_q;
            end
            if (frame_start_c)  overflow_out <= 1'b0;
            else if (fifo_drop) overflow_out <= 1'b1;
        end
    end

    keypoint_fifo #(
        .WIDTH (KP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_keypoint_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (kp_valid_q),
        .push_data (kp_q),
        .pop       (fifo_pop),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head      = keypoint_t'(head_bits);
    assign fifo_pop  = !fifo_empty && keypoint_ready_in;
    assign fifo_drop = kp_valid_q && fifo_full && !fifo_pop;

    // Head fields are masked while empty so unwritten storage never reaches the outputs.
    assign keypoint_valid_out  = !fifo_empty;
    assign keypoint_hcount_out = fifo_empty ? '0 : HWIDTH'(head.hcount);
    assign keypoint_vcount_out = fifo_empty ? '0 : VWIDTH'(head.vcount);
    assign keypoint_type_out   = !fifo_empty && (head.kp_type == KP_JUNCTION);
    assign frame_done_out      = (state_q == FINISH);

endmodule
